// File: rtl/ripple_cla16_pkg.sv
// Shared constants and state encoding for the ripple_cla16 sequential adder.
package ripple_cla16_pkg;

  localparam int WIDTH   = 16;
  localparam int SLICE_W = 4;
  localparam int NSLICE  = WIDTH / SLICE_W;
  localparam int IDX_W   = $clog2(NSLICE);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NSLICE - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage : ripple_cla16_pkg

// File: rtl/ripple_cla16_cla4.sv
// 4-bit combinational carry-lookahead adder; every carry is a flat sum of products.
module cla4 (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       ci,
  output logic [3:0] s,
  output logic       co
);

  logic [3:0] g;
  logic [3:0] p;
  logic [3:0] c;

  assign g = a & b;
  assign p = a ^ b;

  assign c[0] = ci;
  assign c[1] = g[0] | (p[0] & ci);
  assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & ci);
  assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & ci);
  assign co   = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
              | (p[3] & p[2] & p[1] & p[0] & ci);

  assign s = p ^ c;

endmodule : cla4

// File: rtl/ripple_cla16.sv
// 16-bit adder evaluating one CLA slice per clock, LSB first, carry held in a register.
// Optional signed-overflow output enabled by defining RIPPLE_CLA16_OVF_EN.
module ripple_cla16
  import ripple_cla16_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             c_in,
  output logic [WIDTH-1:0] Output,
  output logic             c_out,
  output logic             ready
`ifdef RIPPLE_CLA16_OVF_EN
  ,
  output logic             ovf
`endif
);

  state_e             state_q;
  logic [IDX_W-1:0]   idx_q;
  logic               carry_q;
  logic               en_q;
  logic [WIDTH-1:0]   a_q;
  logic [WIDTH-1:0]   b_q;
  logic [WIDTH-1:0]   sum_q;
  logic               c_out_q;
  logic               ready_q;
  logic               start;
  logic [SLICE_W-1:0] slice_a;
  logic [SLICE_W-1:0] slice_b;
  logic [SLICE_W-1:0] slice_s;
  logic               slice_co;

  assign start   = en & ~en_q;
  assign slice_a = a_q[idx_q*SLICE_W +: SLICE_W];
  assign slice_b = b_q[idx_q*SLICE_W +: SLICE_W];

  // Single adder slice, time-multiplexed across the four nibbles.
  cla4 u_cla4 (
    .a  (slice_a),
    .b  (slice_b),
    .ci (carry_q),
    .s  (slice_s),
    .co (slice_co)
  );

`ifdef RIPPLE_CLA16_OVF_EN
  logic ovf_q;
  logic carry_into_msb;

  // Carry into bit 15 recovered from the top slice's sum and operand bits.
  assign carry_into_msb = slice_s[SLICE_W-1] ^ slice_a[SLICE_W-1] ^ slice_b[SLICE_W-1];
  assign ovf            = ovf_q;
`endif

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      carry_q <= 1'b0;
      en_q    <= 1'b0;
      // NOTE: operand registers are reset too; they are few flops and this keeps slice_a/b known.
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      c_out_q <= 1'b0;
      ready_q <= 1'b0;
`ifdef RIPPLE_CLA16_OVF_EN
      ovf_q   <= 1'b0;
`endif
    end else begin
      en_q <= en;
      unique case (state_q)
        IDLE, DONE: begin
          if (start) begin
            a_q     <= A;
            b_q     <= B;
            carry_q <= c_in;
            ready_q <= 1'b0;
            idx_q   <= '0;
            state_q <= BUSY;
`ifdef RIPPLE_CLA16_OVF_EN
            ovf_q   <= 1'b0;
`endif
          end
        end
        BUSY: begin
          if (!en) begin
            state_q <= IDLE;
          end else begin
            sum_q[idx_q*SLICE_W +: SLICE_W] <= slice_s;
            carry_q <= slice_co;
            idx_q   <= idx_q + 1'b1;
            if (idx_q == LAST_IDX) begin
              c_out_q <= slice_co;
              ready_q <= 1'b1;
              state_q <= DONE;
`ifdef RIPPLE_CLA16_OVF_EN
              ovf_q   <= carry_into_msb ^ slice_co;
`endif
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign Output = sum_q;
  assign c_out  = c_out_q;
  assign ready  = ready_q;

endmodule : ripple_cla16

// File: tb/tb_ripple_cla16.sv
// Scoreboard bench for ripple_cla16; build with RIPPLE_CLA16_OVF_EN to also check ovf.
module tb_ripple_cla16;

  typedef struct {
    logic [15:0] sum;
    logic        cout;
    logic        ovf;
  } exp_t;

  logic        clk;
  logic        rst;
  logic        en;
  logic [15:0] A;
  logic [15:0] B;
  logic        c_in;
  logic [15:0] Output;
  logic        c_out;
  logic        ready;
`ifdef RIPPLE_CLA16_OVF_EN
  logic        ovf;
`endif

  int   total;
  int   bad;
  exp_t sb_q[$];

  ripple_cla16 dut (
    .clk    (clk),
    .rst    (rst),
    .en     (en),
    .A      (A),
    .B      (B),
    .c_in   (c_in),
    .Output (Output),
    .c_out  (c_out),
    .ready  (ready)
`ifdef RIPPLE_CLA16_OVF_EN
    ,
    .ovf    (ovf)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic exp_t model(input logic [15:0] a, input logic [15:0] b, input logic ci);
    exp_t        e;
    logic [16:0] full;
    full   = {1'b0, a} + {1'b0, b} + {16'd0, ci};
    e.sum  = full[15:0];
    e.cout = full[16];
    e.ovf  = (a[15] == b[15]) && (full[15] != a[15]);
    return e;
  endfunction

  task automatic check_result(input string tag, input exp_t e);
    check({tag, "_sum"},  {16'd0, Output}, {16'd0, e.sum});
    check({tag, "_cout"}, {31'd0, c_out},  {31'd0, e.cout});
`ifdef RIPPLE_CLA16_OVF_EN
    check({tag, "_ovf"},  {31'd0, ovf},    {31'd0, e.ovf});
`endif
  endtask

  // Drops en for one edge, then drives a start edge with the given operands.
  task automatic start_op(input logic [15:0] a, input logic [15:0] b, input logic ci);
    en = 1'b0;
    tick();
    A    = a;
    B    = b;
    c_in = ci;
    en   = 1'b1;
    tick();
  endtask

  task automatic run_add(input string tag, input logic [15:0] a, input logic [15:0] b,
                         input logic ci);
    int   cnt;
    exp_t e;
    sb_q.push_back(model(a, b, ci));
    start_op(a, b, ci);
    check({tag, "_busy"}, {31'd0, ready}, 32'd0);
    cnt = 0;
    while (!ready && cnt < 10) begin
      tick();
      cnt++;
    end
    check({tag, "_latency"}, cnt, 32'd4);
    if (sb_q.size() == 0) begin
      check({tag, "_sb_empty"}, 32'd0, 32'd1);
    end else begin
      e = sb_q.pop_front();
      check_result(tag, e);
      // en stays high and operands change: no restart, result held.
      A = ~a;
      B = a ^ b;
      repeat (3) tick();
      check({tag, "_hold_rdy"}, {31'd0, ready}, 32'd1);
      check_result({tag, "_hold"}, e);
    end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst   = 1'b0;
    en    = 1'b0;
    A     = '0;
    B     = '0;
    c_in  = 1'b0;

    #1 rst = 1'b1;
    #1;
    check("rst_sum",   {16'd0, Output}, 32'd0);
    check("rst_cout",  {31'd0, c_out},  32'd0);
    check("rst_ready", {31'd0, ready},  32'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    run_add("a127",    16'd127,   16'd127,   1'b0);
    run_add("ffff_1",  16'hFFFF,  16'h0001,  1'b0);
    run_add("7fff_c",  16'h7FFF,  16'h0000,  1'b1);
    run_add("zero",    16'h0000,  16'h0000,  1'b0);
    run_add("all1",    16'hFFFF,  16'hFFFF,  1'b1);
    run_add("negovf",  16'h8000,  16'h8000,  1'b0);

    // Abort mid-operation, then rerun the same add.
    start_op(16'h1234, 16'h4321, 1'b0);
    tick();
    tick();
    en = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    check("abort_rdy", {31'd0, ready}, 32'd0);
    run_add("rerun", 16'h1234, 16'h4321, 1'b0);

    // Asynchronous reset landing between edges while BUSY.
    start_op(16'hABCD, 16'h1357, 1'b1);
    tick();
    #3 rst = 1'b1;
    #1;
    check("arst_sum",   {16'd0, Output}, 32'd0);
    check("arst_cout",  {31'd0, c_out},  32'd0);
    check("arst_ready", {31'd0, ready},  32'd0);
`ifdef RIPPLE_CLA16_OVF_EN
    check("arst_ovf",   {31'd0, ovf},    32'd0);
`endif
    @(posedge clk);
    #1 rst = 1'b0;
    en = 1'b0;
    run_add("post_rst", 16'hABCD, 16'h1357, 1'b1);

    for (int i = 0; i < 6; i++) begin
      logic [15:0] ra;
      logic [15:0] rb;
      logic        rc;
      ra = 16'($urandom);
      rb = 16'($urandom);
      rc = 1'($urandom_range(1, 0));
      run_add($sformatf("rnd%0d", i), ra, rb, rc);
    end

    check("sb_drained", sb_q.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_ripple_cla16
